uart_tx_feeder: RTL and testbench
=================================

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, meaning frame payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, meaning FIFO entry count; power of two, minimum 2.
REQ-003 SHALL have CLK_FSM  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have RST_FSM  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have WR_EN  input  1  write request from the host.
REQ-006 SHALL have WR_DATA  input  DATA_SIZE  word to enqueue.
REQ-007 SHALL have CLR_OVF  input  1  clears the OVF flag.
REQ-008 SHALL have TX_BUSY  input  1  registered busy flag from the UART TX FSM.
REQ-009 SHALL have FULL  output  1  FIFO holds DEPTH words.
REQ-010 SHALL have EMPTY  output  1  FIFO holds 0 words.
REQ-011 SHALL have COUNT  output  log2(DEPTH)+1  words currently stored.
REQ-012 SHALL have OVF  output  1  sticky flag: a write was dropped.
REQ-013 SHALL have P_DATA  output  DATA_SIZE  word presented to the TX.
REQ-014 SHALL have DATA_VALID  output  1  single-cycle launch strobe to the TX.

Function
REQ-015 SHALL accept a write on an edge where WR_EN=1 and FULL=0; COUNT increments.
REQ-016 SHALL drop a write when FULL=1, even if a pop occurs on the same edge, and set OVF=1.
REQ-017 SHALL clear OVF on an edge with CLR_OVF=1; a simultaneous dropped write leaves OVF=1 (set wins).
REQ-018 SHALL keep COUNT unchanged when an accepted write and a pop occur on the same edge.
REQ-019 SHALL wrap read and write pointers modulo DEPTH; FULL/EMPTY derive from COUNT, all outputs registered.
REQ-020 SHALL implement the states IDLE, LAUNCH, WAIT_ACK and WAIT_DONE.
REQ-021 IDLE: when EMPTY=0 and TX_BUSY=0 -> LAUNCH; load P_DATA with the head word; DATA_VALID=1.
REQ-022 LAUNCH: lasts exactly one cycle; DATA_VALID returns to 0; -> WAIT_ACK.
REQ-023 WAIT_ACK: when TX_BUSY=1 -> pop the head word and go to WAIT_DONE.
REQ-024 WAIT_ACK timeout: if TX_BUSY=0 for 3 consecutive cycles, go to IDLE without popping, so the same word is relaunched.
REQ-025 WAIT_DONE: when TX_BUSY=0 -> IDLE; the next launch occurs no earlier than the following edge.
REQ-026 SHALL hold P_DATA stable from LAUNCH until TX_BUSY falls in WAIT_DONE.
REQ-027 Latency: a write sampled at edge k into an empty FIFO, with the FSM in IDLE and TX_BUSY=0, SHALL give DATA_VALID=1 for the cycle between edges k+1 and k+2.
REQ-028 DATA_VALID SHALL never be high for two consecutive cycles, and never while TX_BUSY=1.
REQ-029 SHALL let writes proceed in every state, independent of the launch FSM.

Reset
REQ-030 RST_FSM low SHALL immediately force state IDLE, COUNT=0, EMPTY=1, FULL=0, OVF=0, DATA_VALID=0, P_DATA=0 and both pointers to 0.
REQ-031 Reset mid-operation SHALL discard all stored words and any word in flight; there is no replay after release.
REQ-032 The first launch after reset release SHALL need a fresh write.

Structure
REQ-033 SHALL place the feeder state encodings and the DATA_SIZE default in shared package uart_tx_pkg, used alongside the TX FSM.
REQ-034 SHALL implement storage, pointers and COUNT in sub-module uart_tx_fifo; the launch FSM and timeout counter stay in the top.
REQ-035 The timeout counter SHALL be 2 bits wide, cleared on entry to WAIT_ACK.

Verification
REQ-036 Single word: write 0xA5 at edge 10 with TX_BUSY=0 -> DATA_VALID=1 only between edges 11 and 12, P_DATA=0xA5; TX_BUSY=1 at edge 13 -> COUNT=0.
REQ-037 Fill/overflow (DEPTH=8, TX_BUSY=1): 9 writes -> FULL=1, COUNT=8, OVF=1, 9th word absent; CLR_OVF pulse -> OVF=0.
REQ-038 Back-to-back: 3 queued words, TX model holds busy 10 cycles per frame -> three DATA_VALID pulses in write order, each after TX_BUSY falls, none while TX_BUSY=1.
REQ-039 Timeout: TX model never raises busy -> DATA_VALID pulses every 5 cycles with the same P_DATA and COUNT unchanged.
REQ-040 Wrap and simultaneous events: 20 words with a write and a pop on the same edges -> COUNT constant and output order matches input across pointer wrap.
REQ-041 Reset mid-frame: assert RST_FSM in WAIT_DONE with COUNT=3 -> all outputs at reset values immediately; no DATA_VALID after release until a new write.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: feeder FSM encodings and payload default.
package uart_tx_pkg;

    localparam int unsigned DefaultDataSize = 8;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWaitAck,
        StWaitDone
    } feeder_state_e;

    // Timeout counter value on the third consecutive idle cycle in WAIT_ACK
    localparam logic [1:0] AckTimeout = 2'd2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular word store for the TX feeder: storage, wrapping pointers, occupancy and overflow flag.
module uart_tx_fifo import uart_tx_pkg::*; #(
    parameter int unsigned DATA_SIZE = DefaultDataSize,
    parameter int unsigned DEPTH     = 8,
    localparam int unsigned PtrW     = $clog2(DEPTH),
    localparam int unsigned CntW     = $clog2(DEPTH) + 1
) (
    input  logic                 CLK_FSM,
    input  logic                 RST_FSM,
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 pop,
    input  logic                 clr_ovf,
    output logic                 full,
    output logic                 empty,
    output logic [CntW-1:0]      count,
    output logic                 ovf,
    output logic [DATA_SIZE-1:0] head
);

    localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q, count_d;
    logic                 full_q, empty_q, ovf_q, ovf_d;
    logic                 wr_accept, wr_drop, pop_ok;

    // A full FIFO drops the write even when a pop frees a slot on the same edge
    assign wr_accept = wr_en & ~full_q;
    assign wr_drop   = wr_en & full_q;
    assign pop_ok    = pop & ~empty_q;

    always_comb begin
        count_d = count_q;
        case ({wr_accept, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (wr_drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK_FSM or negedge RST_FSM) begin
        if (!RST_FSM) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == FullCount);
            empty_q <= (count_d == '0);
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge CLK_FSM) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;
    assign ovf   = ovf_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host words and hands them one at a time to the UART TX FSM with a launch strobe,
// relaunching a word the TX never acknowledged.
module uart_tx_feeder import uart_tx_pkg::*; #(
    parameter int unsigned DATA_SIZE = DefaultDataSize,
    parameter int unsigned DEPTH     = 8,
    localparam int unsigned CntW     = $clog2(DEPTH) + 1
) (
    input  logic                 CLK_FSM,
    input  logic                 RST_FSM,
    input  logic                 WR_EN,
    input  logic [DATA_SIZE-1:0] WR_DATA,
    input  logic                 CLR_OVF,
    input  logic                 TX_BUSY,
    output logic                 FULL,
    output logic                 EMPTY,
    output logic [CntW-1:0]      COUNT,
    output logic                 OVF,
    output logic [DATA_SIZE-1:0] P_DATA,
    output logic                 DATA_VALID
);

    feeder_state_e        state_q, state_d;
    logic [1:0]           tmo_q, tmo_d;
    logic                 dv_q, dv_d;
    logic [DATA_SIZE-1:0] pdata_q, pdata_d;
    logic [DATA_SIZE-1:0] head;
    logic                 pop;

    uart_tx_fifo #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .CLK_FSM (CLK_FSM),
        .RST_FSM (RST_FSM),
        .wr_en   (WR_EN),
        .wr_data (WR_DATA),
        .pop     (pop),
        .clr_ovf (CLR_OVF),
        .full    (FULL),
        .empty   (EMPTY),
        .count   (COUNT),
        .ovf     (OVF),
        .head    (head)
    );

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        dv_d    = 1'b0;
        pdata_d = pdata_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!EMPTY && !TX_BUSY) begin
                    state_d = StLaunch;
                    dv_d    = 1'b1;
                    pdata_d = head;
                end
            end
            StLaunch: begin
                state_d = StWaitAck;
                tmo_d   = '0;
            end
            StWaitAck: begin
                // The word is only retired once the TX shows it took it
                if (TX_BUSY) begin
                    pop     = 1'b1;
                    state_d = StWaitDone;
                end else if (tmo_q == AckTimeout) begin
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 2'd1;
                end
            end
            StWaitDone: begin
                if (!TX_BUSY) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK_FSM or negedge RST_FSM) begin
        if (!RST_FSM) begin
            state_q <= StIdle;
            tmo_q   <= '0;
            dv_q    <= 1'b0;
            pdata_q <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            dv_q    <= dv_d;
            pdata_q <= pdata_d;
        end
    end

    assign DATA_VALID = dv_q;
    assign P_DATA     = pdata_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a simple registered TX busy model.
module tb_uart_tx_feeder;

    logic       CLK_FSM = 1'b0;
    logic       RST_FSM = 1'b0;
    logic       WR_EN = 1'b0;
    logic [7:0] WR_DATA = 8'h00;
    logic       CLR_OVF = 1'b0;
    logic       TX_BUSY;
    logic       FULL, EMPTY, OVF, DATA_VALID;
    logic [3:0] COUNT;
    logic [7:0] P_DATA;

    logic       busy_man = 1'b0;
    int         mode = 0;
    int         busy_cnt = 0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic       dv_prev = 1'b0;
    logic [7:0] launches[$];
    int         dv_cycles[$];

    uart_tx_feeder #(
        .DATA_SIZE (8),
        .DEPTH     (8)
    ) dut (
        .CLK_FSM    (CLK_FSM),
        .RST_FSM    (RST_FSM),
        .WR_EN      (WR_EN),
        .WR_DATA    (WR_DATA),
        .CLR_OVF    (CLR_OVF),
        .TX_BUSY    (TX_BUSY),
        .FULL       (FULL),
        .EMPTY      (EMPTY),
        .COUNT      (COUNT),
        .OVF        (OVF),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID)
    );

    always #5 CLK_FSM = ~CLK_FSM;

    always @(posedge CLK_FSM) cyc <= cyc + 1;

    // TX model: busy for 10 cycles starting the edge after it sees the strobe
    always @(posedge CLK_FSM) begin
        if (mode != 1) busy_cnt <= 0;
        else if (DATA_VALID) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    assign TX_BUSY = (mode == 1) ? (busy_cnt != 0) : busy_man;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    always @(negedge CLK_FSM) begin
        if (RST_FSM && DATA_VALID) begin
            check("dv_while_busy", 32'(TX_BUSY), 0);
            check("dv_two_cycles", 32'(dv_prev), 0);
            launches.push_back(P_DATA);
            dv_cycles.push_back(cyc);
        end
        dv_prev <= RST_FSM && DATA_VALID;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK_FSM);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] d);
        WR_EN = 1'b1;
        WR_DATA = d;
        step(1);
        WR_EN = 1'b0;
    endtask

    task automatic clr_pulse();
        CLR_OVF = 1'b1;
        step(1);
        CLR_OVF = 1'b0;
    endtask

    task automatic wait_dv(input string tag);
        for (int i = 0; i < 60 && !DATA_VALID; i++) step(1);
        check(tag, 32'(DATA_VALID), 1);
    endtask

    task automatic clear_log();
        launches.delete();
        dv_cycles.delete();
    endtask

    task automatic check_order(input string tag, input int n, input logic [7:0] first);
        check({tag, "_n"}, 32'(launches.size()), 32'(n));
        for (int i = 0; i < n && i < launches.size(); i++) begin
            check(tag, 32'(launches[i]), 32'(first) + 32'(i));
        end
    endtask

    initial begin
        // Reset values
        step(3);
        check("rst_count", 32'(COUNT), 0);
        check("rst_empty", 32'(EMPTY), 1);
        check("rst_full", 32'(FULL), 0);
        check("rst_ovf", 32'(OVF), 0);
        check("rst_dv", 32'(DATA_VALID), 0);
        check("rst_pdata", 32'(P_DATA), 0);
        RST_FSM = 1'b1;
        step(2);

        // Single word: write at edge k, strobe between k+1 and k+2, pop when busy seen
        wr(8'hA5);
        check("one_count", 32'(COUNT), 1);
        check("one_dv_early", 32'(DATA_VALID), 0);
        step(1);
        check("one_dv", 32'(DATA_VALID), 1);
        check("one_pdata", 32'(P_DATA), 32'hA5);
        step(1);
        check("one_dv_low", 32'(DATA_VALID), 0);
        busy_man = 1'b1;
        step(1);
        check("one_popped", 32'(COUNT), 0);
        check("one_empty", 32'(EMPTY), 1);
        busy_man = 1'b0;
        step(3);
        check("one_pulses", 32'(launches.size()), 1);

        // Fill and overflow with TX held busy
        clear_log();
        busy_man = 1'b1;
        for (int i = 0; i < 9; i++) wr(8'(8'h10 + i));
        check("fill_full", 32'(FULL), 1);
        check("fill_count", 32'(COUNT), 8);
        check("fill_ovf", 32'(OVF), 1);
        clr_pulse();
        check("ovf_clr", 32'(OVF), 0);
        CLR_OVF = 1'b1;
        wr(8'hEE);
        CLR_OVF = 1'b0;
        check("ovf_set_wins", 32'(OVF), 1);
        check("ovf_count8", 32'(COUNT), 8);
        clr_pulse();
        check("ovf_clr2", 32'(OVF), 0);
        mode = 1;
        wait_dv("ovf_launch");
        check("ovf_head", 32'(P_DATA), 32'h10);
        step(1);
        wr(8'h99);
        check("pop_drop_count", 32'(COUNT), 7);
        check("pop_drop_ovf", 32'(OVF), 1);
        check("pop_drop_full", 32'(FULL), 0);
        clr_pulse();
        for (int i = 0; i < 200 && !(launches.size() == 8 && EMPTY); i++) step(1);
        step(15);
        check_order("ovf_order", 8, 8'h10);

        // Back-to-back frames paced by the TX busy window
        mode = 0;
        busy_man = 1'b1;
        step(2);
        clear_log();
        wr(8'h21);
        wr(8'h22);
        wr(8'h23);
        mode = 1;
        for (int i = 0; i < 100 && !(launches.size() == 3 && EMPTY); i++) step(1);
        step(15);
        check_order("b2b_order", 3, 8'h21);
        if (dv_cycles.size() == 3) begin
            check("b2b_gap1", 32'(dv_cycles[1] - dv_cycles[0]), 13);
            check("b2b_gap2", 32'(dv_cycles[2] - dv_cycles[1]), 13);
        end else begin
            check("b2b_gaps", 32'(dv_cycles.size()), 3);
        end
        check("b2b_count", 32'(COUNT), 0);

        // Timeout: TX never answers, same word relaunched every 5 cycles
        mode = 0;
        busy_man = 1'b0;
        step(2);
        clear_log();
        wr(8'h3C);
        step(1);
        check("lat_dv", 32'(DATA_VALID), 1);
        for (int i = 0; i < 60 && dv_cycles.size() < 4; i++) step(1);
        check("tmo_pulses", 32'(dv_cycles.size()), 4);
        for (int k = 0; k < 3 && k + 1 < dv_cycles.size(); k++) begin
            check("tmo_period", 32'(dv_cycles[k+1] - dv_cycles[k]), 5);
            check("tmo_data", 32'(launches[k+1]), 32'h3C);
        end
        check("tmo_count", 32'(COUNT), 1);
        wait_dv("tmo_relaunch");
        step(1);
        busy_man = 1'b1;
        step(1);
        check("tmo_popped", 32'(COUNT), 0);
        busy_man = 1'b0;
        step(3);

        // Wrap: write and pop on the same edge for 20 frames
        busy_man = 1'b1;
        clear_log();
        wr(8'h40);
        wr(8'h41);
        wr(8'h42);
        mode = 1;
        for (int n = 0; n < 20; n++) begin
            wait_dv("wrap_launch");
            step(1);
            wr(8'(8'h43 + n));
            check("wrap_count", 32'(COUNT), 3);
        end
        for (int i = 0; i < 200 && !(launches.size() == 23 && EMPTY); i++) step(1);
        step(15);
        check_order("wrap_order", 23, 8'h40);

        // Reset in WAIT_DONE with three words still queued
        mode = 0;
        busy_man = 1'b1;
        step(2);
        wr(8'h70);
        wr(8'h71);
        wr(8'h72);
        wr(8'h73);
        busy_man = 1'b0;
        wait_dv("rst_launch");
        step(1);
        busy_man = 1'b1;
        step(1);
        check("mid_count", 32'(COUNT), 3);
        check("mid_pdata", 32'(P_DATA), 32'h70);
        #2;
        RST_FSM = 1'b0;
        #1;
        check("mid_rst_count", 32'(COUNT), 0);
        check("mid_rst_empty", 32'(EMPTY), 1);
        check("mid_rst_full", 32'(FULL), 0);
        check("mid_rst_ovf", 32'(OVF), 0);
        check("mid_rst_dv", 32'(DATA_VALID), 0);
        check("mid_rst_pdata", 32'(P_DATA), 0);
        @(posedge CLK_FSM);
        #1;
        RST_FSM = 1'b1;
        busy_man = 1'b0;
        clear_log();
        step(20);
        check("post_rst_quiet", 32'(launches.size()), 0);
        check("post_rst_count", 32'(COUNT), 0);
        check("post_rst_empty", 32'(EMPTY), 1);
        wr(8'h88);
        step(1);
        check("fresh_dv", 32'(DATA_VALID), 1);
        check("fresh_pdata", 32'(P_DATA), 32'h88);
        step(3);
        check("fresh_pulses", 32'(launches.size()), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
